// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer and the bus datapath:
// opcode constants, the control-step enum, ALU one-hot bit positions and an
// opcode classifier. CU_BRANCH_EN enables the conditional branch opcode.
package cpu_pkg;

  // Opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU one-hot bit positions, shared with the datapath
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 8;
  localparam int ALU_OR  = 9;

  // Control steps
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  // Instruction families that share an execute sequence
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_ALUI = 3'd2,
    CLS_ALU  = 3'd3,
    CLS_LD   = 3'd4,
    CLS_ST   = 3'd5,
    CLS_BR   = 3'd6,
    CLS_HALT = 3'd7
  } op_class_t;

  // Unknown opcodes fall into the nop family
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_LD:                    return CLS_LD;
      OP_LDI:                   return CLS_LDI;
      OP_ST:                    return CLS_ST;
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:            return CLS_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: return CLS_ALUI;
`ifdef CU_BRANCH_EN
      OP_BR:                    return CLS_BR;
`endif
      OP_HALT:                  return CLS_HALT;
      default:                  return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cu_step_counter.sv
// Control-step register and next-step logic. Fetch is fixed at T0-T2; the
// opcode family picks how far the execute phase runs before returning to T0.
module cu_step_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  output state_t     state
);

  state_t    state_q, state_d;
  op_class_t cls;

  // Next step: linear walk, with family-dependent exits at T3, T5 and T6
  always_comb begin
    state_d = state_q;
    cls     = op_class(opcode);
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_HALT: state_d = ST_HALT;
          CLS_NOP:  state_d = ST_T0;
          default:  state_d = ST_T4;
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (cls == CLS_LD || cls == CLS_ST || cls == CLS_BR) ? ST_T6 : ST_T0;
      ST_T6:   state_d = (cls == CLS_LD || cls == CLS_ST) ? ST_T7 : ST_T0;
      ST_T7:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // Step register; clr drops straight to RST so strobes clear mid-cycle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_RST;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: decodes the current step and ir[31:27] into
// datapath strobes (Moore outputs). CU_BRANCH_EN adds the conditional branch;
// without it the branch opcode runs as nop and con is ignored.
// ALU_W must be at least 10 to hold the OR bit.
module control_unit
  import cpu_pkg::*;
#(
  parameter int ALU_W = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir,
  input  logic              con,
  output logic              PCout, MARin, IncPC, Zin, Zlowout, PCin,
  output logic              MDRRead, MDRin, MDRout, IRin, Yin, Cout, BAout,
  output logic              Gra, Grb, Grc, Rin_in, Rout_in,
  output logic              RAMread, RAMwrite, CONin,
  output logic [ALU_W-1:0]  ALUControl,
  output logic              run
);

  state_t          state;
  op_class_t       cls;
  logic [4:0]      opcode;
  logic [ALU_W-1:0] alu_op;

  assign opcode = ir[31:27];

  cu_step_counter u_step (
    .clk    (clk),
    .clr    (clr),
    .opcode (opcode),
    .state  (state)
  );

`ifdef CU_BRANCH_EN
  logic unused_ir;
  assign unused_ir = ^ir[26:0];
`else
  logic unused_ir_con;
  assign unused_ir_con = ^{ir[26:0], con};
`endif

  // Operation selected by the opcode for the ALU step of arithmetic families
  always_comb begin
    alu_op = '0;
    case (opcode)
      OP_SUB:          alu_op[ALU_SUB] = 1'b1;
      OP_AND, OP_ANDI: alu_op[ALU_AND] = 1'b1;
      OP_OR,  OP_ORI:  alu_op[ALU_OR]  = 1'b1;
      default:         alu_op[ALU_ADD] = 1'b1;
    endcase
  end

  // Strobe decode per step; every step names its single bus driver
  always_comb begin
    {PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin, MDRout, IRin,
     Yin, Cout, BAout, Gra, Grb, Grc, Rin_in, Rout_in, RAMread, RAMwrite,
     CONin} = '0;
    ALUControl = '0;
    run        = (state != ST_RST) && (state != ST_HALT);
    cls        = op_class(opcode);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_ALU, CLS_ALUI:       begin Grb = 1'b1; Rout_in = 1'b1; Yin = 1'b1; end
          CLS_BR:                  begin Gra = 1'b1; Rout_in = 1'b1; CONin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_LDI, CLS_LD, CLS_ST: begin
            Cout = 1'b1; Zin = 1'b1; ALUControl[ALU_ADD] = 1'b1;
          end
          CLS_ALUI: begin Cout = 1'b1; Zin = 1'b1; ALUControl = alu_op; end
          CLS_ALU:  begin Grc = 1'b1; Rout_in = 1'b1; Zin = 1'b1; ALUControl = alu_op; end
          CLS_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_LDI, CLS_ALU, CLS_ALUI: begin Zlowout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          CLS_LD, CLS_ST:             begin Zlowout = 1'b1; MARin = 1'b1; end
          CLS_BR: begin Cout = 1'b1; Zin = 1'b1; ALUControl[ALU_ADD] = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1; end
          CLS_ST: begin Gra = 1'b1; Rout_in = 1'b1; MDRin = 1'b1; end
          CLS_BR: begin Zlowout = con; PCin = con; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin_in = 1'b1; end
          CLS_ST: RAMwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
